perceptron_eval: RTL and testbench

- Forward-pass stage of the single-layer perceptron. It sits directly upstream of the weight-update stage.
- Takes a binary input vector x, the current packed weights and the bias, and computes sum = bias + Σ x[i]·w[i] serially, one input per cycle.
- Thresholds the sum and presents y (plus the raw sum) to the training stage over a valid/ready handshake.
- The weights/bias bus is the one driven by the weight-update stage.

---
 rtl/perceptron_eval_pkg.sv | 12 +
 rtl/perceptron_eval_if.sv | 29 ++
 rtl/perceptron_eval_ff.sv | 20 ++
 rtl/perceptron_eval.sv | 97 +++++++++
 tb/tb_perceptron_eval.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/perceptron_eval_pkg.sv
// rtl/perceptron_eval_pkg.sv - shared widths and state encoding for the perceptron stages
package perceptron_eval_pkg;

  localparam int WEIGHT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/perceptron_eval_if.sv
// rtl/perceptron_eval_if.sv - sample-in / result-out handshake bundle for perceptron_eval
interface perceptron_eval_if
  import perceptron_eval_pkg::*;
#(
  parameter int N = 8,
  parameter int W = WEIGHT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     x;
  logic [W*N-1:0]   weights;
  logic [W-1:0]     bias;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic [W-1:0]     sum;

  modport master (
    output in_valid, x, weights, bias, out_ready,
    input  in_ready, out_valid, y, sum
  );

  modport slave (
    input  in_valid, x, weights, bias, out_ready,
    output in_ready, out_valid, y, sum
  );

endinterface

// File: rtl/perceptron_eval_ff.sv
// rtl/perceptron_eval_ff.sv - enable flip-flop with asynchronous active-low clear
module perceptron_eval_ff #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/perceptron_eval.sv
// rtl/perceptron_eval.sv - serial perceptron forward pass: bias + sum of selected weights, thresholded
module perceptron_eval
  import perceptron_eval_pkg::*;
#(
  parameter int N = 8,
  parameter int W = WEIGHT_W
) (
  input  logic             clk,
  input  logic             rst,
  perceptron_eval_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state;
  logic [CW-1:0]    idx;
  logic [N-1:0]     x_s;
  logic [W*N-1:0]   w_s;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_d;
  logic [W-1:0]     addend;
  logic             accept;
  logic             last;
  logic             acc_en;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [W-1:0]     y_r;
  logic [W-1:0]     sum_r;

  assign accept = (state == IDLE) && bus.in_valid && in_ready_r;
  assign last   = (idx == CW'(N - 1));
  assign addend = x_s[idx] ? w_s[W*int'(idx) +: W] : '0;
  // In IDLE the accumulator loads the bias on accept; in ACCUM it adds one term per cycle.
  assign acc_d  = (state == IDLE) ? bus.bias : acc + addend;
  assign acc_en = accept || (state == ACCUM);

  perceptron_eval_ff #(.W(W)) u_acc (
    .clk   (clk),
    .rst_n (rst),
    .en    (acc_en),
    .d     (acc_d),
    .q     (acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      x_s         <= '0;
      w_s         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      y_r         <= '0;
      sum_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (accept) begin
            x_s        <= bus.x;
            w_s        <= bus.weights;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= ACCUM;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ACCUM: begin
          idx <= idx + 1'b1;
          if (last) begin
            idx         <= '0;
            sum_r       <= acc_d;
            y_r         <= {{(W-1){1'b0}}, ~acc_d[W-1]};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Raising in_ready here lets the next sample land right after the handshake.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.y         = y_r;
  assign bus.sum       = sum_r;

endmodule

// File: tb/tb_perceptron_eval.sv
// tb/tb_perceptron_eval.sv - directed and randomized checks of perceptron_eval against an arithmetic model
module tb_perceptron_eval;

  localparam int N = 8;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  perceptron_eval_if #(.N(N), .W(W)) bus ();

  perceptron_eval #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_sum(input logic [7:0] xv, input logic [255:0] wv,
                                            input logic [31:0] bv);
    longint unsigned s;
    s = longint'(bv);
    for (int i = 0; i < N; i++) begin
      if (xv[i]) s = s + longint'(wv[32*i +: 32]);
    end
    return s[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] xv, input logic [255:0] wv,
                     input logic [31:0] bv, input int hold, input bit corrupt);
    logic [31:0] es;
    logic [31:0] ey;
    int          n;
    es = model_sum(xv, wv, bv);
    ey = ($signed(es) >= 0) ? 32'd1 : 32'd0;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.x        = xv;
    bus.weights  = wv;
    bus.bias     = bv;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".busy"}, {31'd0, bus.in_ready}, 32'd0);
    if (corrupt) begin
      bus.weights = {8{32'h0000_0100}};
      bus.x       = ~xv;
      bus.bias    = $urandom;
    end
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, n, N);
    chk({tag, ".sum"}, bus.sum, es);
    chk({tag, ".y"}, bus.y, ey);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, ".hold_sum"}, bus.sum, es);
      chk({tag, ".hold_y"}, bus.y, ey);
      chk({tag, ".hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, ".ready_back"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [255:0] wv;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.weights   = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.sum", bus.sum, 32'd0);
    chk("rst.y", bus.y, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", {31'd0, bus.in_ready}, 32'd1);

    run("ones", 8'hFF, {8{32'd1}}, 32'd0, 0, 1'b0);
    run("neg1", 8'h0F, {8{32'd1}}, 32'hFFFF_FFFB, 0, 1'b0);
    run("zero", 8'h1F, {8{32'd1}}, 32'hFFFF_FFFB, 0, 1'b0);
    for (int i = 0; i < N; i++) wv[32*i +: 32] = $urandom;
    run("x0", 8'h00, wv, 32'd7, 0, 1'b0);
    wv = '0;
    wv[31:0]  = 32'h7FFF_FFFF;
    wv[63:32] = 32'd1;
    run("ovf", 8'h03, wv, 32'd0, 0, 1'b0);
    for (int i = 0; i < N; i++) wv[32*i +: 32] = 32'($urandom_range(0, 64)) - 32'd32;
    run("bp", 8'hA5, wv, 32'd3, 5, 1'b1);

    wv = {8{32'd9}};
    bus.in_valid = 1'b1;
    bus.x        = 8'hFF;
    bus.weights  = wv;
    bus.bias     = 32'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort.sum", bus.sum, 32'd0);
    chk("abort.y", bus.y, 32'd0);
    chk("abort.in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.rel_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort.rel_valid", {31'd0, bus.out_valid}, 32'd0);
    wv = '0;
    wv[31:0] = 32'd3;
    run("fresh", 8'h01, wv, 32'd2, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < N; i++) wv[32*i +: 32] = $urandom;
      run($sformatf("rnd%0d", t), 8'($urandom), wv, $urandom,
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
